nibble_frame_rx: RTL
====================

// Module: nibble_frame_rx
// PURPOSE
// Serial receiver upstream of the 4-bit parity checker: deframes a start/data/parity/stop bit stream
// into parallel nibbles, verifies the sender's parity bit and hands each word on through a valid/ready
// register stage. Its out_data feeds the checker's A input; it also keeps a saturating error count.
// PARAMETERS
// DATA_W      4  data bits per frame, sent LSB first
// PARITY_ODD  0  0: data+parity bit hold an even number of ones (checker out=1); 1: odd
// ERR_CNT_W   8  width of the saturating error counter
// PORTS
// clk        in   1          single clock, rising edge
// rst_n      in   1          asynchronous active-low reset
// rx_i       in   1          serial line, idles high, asynchronous to clk
// bit_en     in   1          one-cycle strobe marking the bit-sample point (one per bit period)
// out_ready  in   1          downstream accepts out_data this cycle
// clr_cnt    in   1          synchronous clear of err_cnt
// out_data   out  DATA_W     received word, stable while out_valid=1
// out_valid  out  1          out_data/out_par_err hold an unconsumed word
// out_par_err out 1          parity-mismatch flag travelling with out_data
// frame_err  out  1          one-cycle pulse: stop bit sampled as 0
// overrun    out  1          one-cycle pulse: completed word dropped, output register still full
// busy       out  1          1 whenever FSM is not IDLE
// err_cnt    out  ERR_CNT_W  saturating count of parity + frame errors
// BEHAVIOUR
// - Reset (async, rst_n=0): all outputs 0, err_cnt=0, sync flops=1, FSM=IDLE, bit counter=0.
// - rx_i passes a 2-flop synchronizer (rx_s); all decisions use rx_s, 2 clk latency from rx_i.
// - FSM advances only on cycles with bit_en=1; with bit_en=0 all state holds.
// - IDLE: rx_s=0 -> DATA, bit counter=0. rx_s=1 stays IDLE.
// - DATA: shift reg[cnt]=rx_s, cnt++; after DATA_W-th bit -> PARITY. cnt wraps to 0.
// - PARITY: store p=rx_s -> STOP.
// - STOP: always -> IDLE. par_bad = (^data ^ p) != PARITY_ODD.
//   - rx_s=0: frame_err pulses next cycle, word discarded, out_valid unchanged, err_cnt+1.
//   - rx_s=1 and slot free (out_valid=0, or out_valid&out_ready this cycle): on this edge
//     out_data<=data, out_par_err<=par_bad, out_valid<=1. par_bad=1 -> err_cnt+1.
//   - rx_s=1 and slot full (out_valid=1, out_ready=0): new word dropped, old word kept, overrun
//     pulses one cycle; par_bad still counts.
// - Handshake: out_valid&out_ready on an edge clears out_valid (unless reloaded on same edge);
//   out_data/out_par_err never change while out_valid=1 and out_ready=0.
// - err_cnt: +1 per error event (max one per frame), saturates at all-ones; clr_cnt has priority
//   over increment in the same cycle.
// - rx_s glitches back to 1 after start are not rechecked; a frame always runs to STOP.
// - rst_n low mid-frame: partial word lost, no pulses; receiver resumes at next start bit.
// - busy=1 in DATA/PARITY/STOP; throughput one word per DATA_W+3 bit_en strobes.
// TESTING
// 1 Frame 0,0101(LSB first=4'hA),p=0,1, out_ready=1 -> out_valid one cycle, out_data=4'hA,
//   out_par_err=0, err_cnt=0.
// 2 Frame data 4'h8, p=0 (even mode) -> out_data=4'h8, out_par_err=1, err_cnt=1; PARITY_ODD=1
//   build: same frame -> out_par_err=0.
// 3 Frame 4'hC, p=0, stop=0 -> frame_err single pulse, out_valid stays 0, err_cnt+1.
// 4 out_ready=0, frames 4'hD then 4'h3 -> out_data stays 4'hD, overrun pulses once; raise
//   out_ready -> 4'hD consumed, out_valid=0.
// 5 rst_n low after 2 data bits -> all outputs 0 immediately; next frame 4'hD,p=1 -> 4'hD, no error.
// 6 Force 255 parity errors, then one more -> err_cnt holds 8'hFF; clr_cnt with error same cycle -> 0.

Source files
------------

// File: rtl/nibble_frame_rx.sv
// rtl/nibble_frame_rx.sv - serial start/data/parity/stop deframer with valid/ready output stage
//
// Purpose: samples a serial line on bit_en strobes, assembles DATA_W-bit words (LSB first),
// checks the sender's parity bit and presents each word through a one-deep valid/ready register.
// Framing and parity errors are tallied in a saturating counter.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   rx_i                 serial line, idles high, asynchronous to clk
//   bit_en               one-cycle strobe at each bit-sample point
//   out_ready            downstream accepts out_data this cycle
//   clr_cnt              synchronous clear of err_cnt (wins over increment)
//   out_data/out_valid   received word and its valid flag
//   out_par_err          parity-mismatch flag travelling with out_data
//   frame_err            one-cycle pulse: stop bit sampled low
//   overrun              one-cycle pulse: completed word dropped, output slot full
//   busy                 receiver is inside a frame
//   err_cnt              saturating parity + frame error count
module nibble_frame_rx #(
  parameter int DATA_W     = 4,
  parameter int PARITY_ODD = 0,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  input  logic                 bit_en,
  input  logic                 out_ready,
  input  logic                 clr_cnt,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_valid,
  output logic                 out_par_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_s_q, rx_s_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]    shift_q, shift_d;
  logic                 par_q, par_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_par_err_q, out_par_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic par_bad;
  logic slot_free;
  logic err_inc;

  // Overall parity of data plus the received parity bit, compared against the selected sense.
  assign par_bad   = (^shift_q) ^ par_q ^ PAR_ODD;
  // The slot can take a new word if empty or being drained on this same edge.
  assign slot_free = ~out_valid_q | out_ready;

  always_comb begin
    rx_meta_d     = rx_i;
    rx_s_d        = rx_meta_q;
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    par_d         = par_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q & ~out_ready;
    out_par_err_d = out_par_err_q;
    frame_err_d   = 1'b0;
    overrun_d     = 1'b0;
    err_inc       = 1'b0;

    if (bit_en) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_d = S_DATA;
            cnt_d   = '0;
          end
        end
        S_DATA: begin
          shift_d[cnt_q] = rx_s_q;
          if (cnt_q == LAST_BIT) begin
            cnt_d   = '0;
            state_d = S_PARITY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_PARITY: begin
          par_d   = rx_s_q;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (!rx_s_q) begin
            // Bad stop bit: the word is discarded and only the framing error counts.
            frame_err_d = 1'b1;
            err_inc     = 1'b1;
          end else begin
            err_inc = par_bad;
            if (slot_free) begin
              out_data_d    = shift_q;
              out_par_err_d = par_bad;
              out_valid_d   = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);

    if (clr_cnt) begin
      err_cnt_d = '0;
    end else if (err_inc && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      shift_q       <= '0;
      par_q         <= 1'b0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_par_err_q <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_q     <= 1'b0;
      busy_q        <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      rx_meta_q     <= rx_meta_d;
      rx_s_q        <= rx_s_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      par_q         <= par_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_par_err_q <= out_par_err_d;
      frame_err_q   <= frame_err_d;
      overrun_q     <= overrun_d;
      busy_q        <= busy_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_par_err = out_par_err_q;
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;
  assign busy        = busy_q;
  assign err_cnt     = err_cnt_q;

endmodule
